// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one ALU via round-robin (ALU_ARB_FIXED_PRIO_EN selects fixed req0 priority)
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_result_o,
  output logic              rsp0_zero_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_result_o,
  output logic              rsp1_zero_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              busy_o
);
  logic              issue_vld_q, issue_id_q;
  logic [CTRL_W-1:0] issue_ctrl_q;
  logic [DATA_W-1:0] issue_src1_q, issue_src2_q;
  logic              rsp0_valid_q, rsp0_zero_q, rsp1_valid_q, rsp1_zero_q;
  logic [DATA_W-1:0] rsp0_result_q, rsp1_result_q;
  logic              elig0, elig1, g0, g1;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic              last_grant_q;
`endif
  // a same-cycle ack frees the requester's slot
  always_comb begin
    elig0 = req0_valid_i & ~((issue_vld_q & ~issue_id_q) | (rsp0_valid_q & ~rsp0_ready_i));
    elig1 = req1_valid_i & ~((issue_vld_q & issue_id_q) | (rsp1_valid_q & ~rsp1_ready_i));
`ifdef ALU_ARB_FIXED_PRIO_EN
    g0 = elig0 & ~rst_i;
`else
    g0 = elig0 & (~elig1 | last_grant_q) & ~rst_i;
`endif
    g1 = elig1 & ~g0 & ~rst_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      issue_vld_q   <= 1'b0;
      issue_id_q    <= 1'b0;
      issue_ctrl_q  <= '0;
      issue_src1_q  <= '0;
      issue_src2_q  <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
    end else begin
      issue_vld_q <= g0 | g1;
      if (g0 | g1) begin
        issue_id_q   <= g1;
        issue_ctrl_q <= g1 ? req1_ctrl_i : req0_ctrl_i;
        issue_src1_q <= g1 ? req1_src1_i : req0_src1_i;
        issue_src2_q <= g1 ? req1_src2_i : req0_src2_i;
      end
      if (issue_vld_q & ~issue_id_q) begin
        rsp0_valid_q  <= 1'b1;
        rsp0_result_q <= alu_result_i;
        rsp0_zero_q   <= alu_zero_i;
      end else if (rsp0_ready_i) rsp0_valid_q <= 1'b0;
      if (issue_vld_q & issue_id_q) begin
        rsp1_valid_q  <= 1'b1;
        rsp1_result_q <= alu_result_i;
        rsp1_zero_q   <= alu_zero_i;
      end else if (rsp1_ready_i) rsp1_valid_q <= 1'b0;
    end
`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) last_grant_q <= 1'b1;
    else if (g0 | g1) last_grant_q <= g1;
`endif
  assign req0_ready_o  = g0;
  assign req1_ready_o  = g1;
  assign rsp0_valid_o  = rsp0_valid_q;
  assign rsp0_result_o = rsp0_result_q;
  assign rsp0_zero_o   = rsp0_zero_q;
  assign rsp1_valid_o  = rsp1_valid_q;
  assign rsp1_result_o = rsp1_result_q;
  assign rsp1_zero_o   = rsp1_zero_q;
  assign alu_ctrl_o    = issue_vld_q ? issue_ctrl_q : '0;
  assign alu_src1_o    = issue_vld_q ? issue_src1_q : '0;
  assign alu_src2_o    = issue_vld_q ? issue_src2_q : '0;
  assign busy_o        = issue_vld_q | rsp0_valid_q | rsp1_valid_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: randomized + directed scoreboard bench for alu_share_arb against a transaction-level model
module tb_alu_share_arb;
  localparam int DW = 32;
  localparam int CW = 4;
  typedef struct {
    int          due;
    logic [DW-1:0] res;
    logic        z;
  } exp_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero;
  logic [CW-1:0] req_ctrl [2];
  logic [DW-1:0] req_src1 [2];
  logic [DW-1:0] req_src2 [2];
  logic [DW-1:0] rsp_res  [2];
  logic [DW-1:0] alu_src1_o, alu_src2_o, alu_result_i;
  logic [CW-1:0] alu_ctrl_o;
  logic          alu_zero_i, busy_o;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc = 0;
  exp_t mq [2][$];
  exp_t sb [2][$];
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  function automatic logic [DW-1:0] alu(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd6: return a - b;
      4'd7: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return a ^ b;
    endcase
  endfunction
  assign alu_result_i = alu(alu_ctrl_o, alu_src1_o, alu_src2_o);
  assign alu_zero_i   = (alu_result_i == '0);
  alu_share_arb #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req_valid[0]), .req0_ready_o(req_ready[0]), .req0_ctrl_i(req_ctrl[0]),
    .req0_src1_i(req_src1[0]), .req0_src2_i(req_src2[0]),
    .rsp0_valid_o(rsp_valid[0]), .rsp0_ready_i(rsp_ready[0]), .rsp0_result_o(rsp_res[0]), .rsp0_zero_o(rsp_zero[0]),
    .req1_valid_i(req_valid[1]), .req1_ready_o(req_ready[1]), .req1_ctrl_i(req_ctrl[1]),
    .req1_src1_i(req_src1[1]), .req1_src2_i(req_src2[1]),
    .rsp1_valid_o(rsp_valid[1]), .rsp1_ready_i(rsp_ready[1]), .rsp1_result_o(rsp_res[1]), .rsp1_zero_o(rsp_zero[1]),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .busy_o(busy_o)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // Reference model: a requester is busy while any accepted op has not yet been acknowledged
  int last_m = 1;
  logic iss_v_m = 1'b0;
  logic [CW-1:0] iss_c;
  logic [DW-1:0] iss_a, iss_b;
  always @(negedge clk_i) begin
    logic [1:0] vis, ack, elig, g;
    exp_t e;
    int x;
    if (rst_i) begin
      mq[0].delete(); mq[1].delete();
      last_m = 1;
      iss_v_m = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        vis[i]  = mq[i].size() > 0 && mq[i][0].due <= cyc;
        ack[i]  = vis[i] && rsp_ready[i];
        elig[i] = req_valid[i] && (mq[i].size() - (ack[i] ? 1 : 0) == 0);
      end
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = (elig == 2'b11) ? 2'b01 : elig;
`else
      g = (elig == 2'b11) ? (last_m == 0 ? 2'b10 : 2'b01) : elig;
`endif
      chk("ready", 128'(req_ready), 128'(g));
      chk("busy", 128'(busy_o), 128'(iss_v_m | vis[0] | vis[1]));
      chk("alu_drive", {alu_ctrl_o, alu_src1_o, alu_src2_o},
          iss_v_m ? {iss_c, iss_a, iss_b} : 128'(0));
      for (int i = 0; i < 2; i++) if (ack[i]) void'(mq[i].pop_front());
      if (g != 2'b00) begin
        x = g[1] ? 1 : 0;
        e.due = cyc + 2;
        e.res = alu(req_ctrl[x], req_src1[x], req_src2[x]);
        e.z   = (e.res == '0);
        mq[x].push_back(e);
        sb[x].push_back(e);
        last_m = x;
        n_acc++;
        iss_v_m = 1'b1;
        iss_c = req_ctrl[x];
        iss_a = req_src1[x];
        iss_b = req_src2[x];
      end else iss_v_m = 1'b0;
    end
  end
  // Monitor: checks each presented response against the scoreboard and the hold/clear rules
  logic [1:0] pv = 2'b00, pr = 2'b00;
  logic [DW-1:0] pres [2];
  logic [1:0] pz;
  always @(negedge clk_i) begin
    if (rst_i) begin
      pv = 2'b00;
      sb[0].delete(); sb[1].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && pr[i]) chk("rsp_clear", 128'(rsp_valid[i]), 128'(0));
        else if (pv[i]) chk("rsp_hold", {rsp_valid[i], rsp_res[i], rsp_zero[i]}, {1'b1, pres[i], pz[i]});
        if (rsp_valid[i] && !pv[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected req%0d at cycle %0d: got result %0h expected no response", i, cyc, rsp_res[i]);
          end else
            chk($sformatf("rsp%0d_data", i), {32'(cyc), rsp_res[i], rsp_zero[i]},
                {32'(sb[i][0].due), sb[i][0].res, sb[i][0].z});
        end
        if (rsp_valid[i] && rsp_ready[i] && sb[i].size() > 0) void'(sb[i].pop_front());
        pv[i] = rsp_valid[i];
        pr[i] = rsp_ready[i];
        pres[i] = rsp_res[i];
        pz[i] = rsp_zero[i];
      end
    end
  end
  task automatic set_req(input int x, input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[x] = v;
    req_ctrl[x] = c;
    req_src1[x] = a;
    req_src2[x] = b;
  endtask
  task automatic next();
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    req_valid = 2'b00;
    rst_i = 1'b1;
    next();
    next();
    rst_i = 1'b0;
  endtask
  initial begin
    int n0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, '0, '0, '0);
    #1;
    chk("reset_outputs", {rsp_valid, req_ready, busy_o, rsp_res[0], rsp_res[1], rsp_zero},
        128'(0));
    chk("reset_alu", {alu_ctrl_o, alu_src1_o, alu_src2_o}, 128'(0));
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 1'b1, 4'd2, 5, 7);
    @(negedge clk_i) chk("t1_ready0", 128'(req_ready[0]), 128'(1));
    next();
    req_valid[0] = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i) chk("t1_rsp0", {rsp_valid[0], rsp_res[0], rsp_zero[0]}, {1'b1, 32'd12, 1'b0});
    @(negedge clk_i) chk("t1_rsp0_clear", 128'(rsp_valid[0]), 128'(0));
    do_reset();
    set_req(0, 1'b1, 4'd6, 9, 9);
    set_req(1, 1'b1, 4'd1, 32'hF0, 32'h0F);
    @(negedge clk_i) chk("t2_grant_first", 128'(req_ready), 128'(2'b01));
    next();
    req_valid[0] = 1'b0;
    @(negedge clk_i) chk("t2_grant_second", 128'(req_ready), 128'(2'b10));
    next();
    req_valid[1] = 1'b0;
    @(negedge clk_i) chk("t2_rsp0", {rsp_valid[0], rsp_res[0], rsp_zero[0]}, {1'b1, 32'd0, 1'b1});
    @(negedge clk_i) chk("t2_rsp1", {rsp_valid[1], rsp_res[1], rsp_zero[1]}, {1'b1, 32'hFF, 1'b0});
    do_reset();
    rsp_ready = 2'b10;
    set_req(0, 1'b1, 4'd0, 32'hFF00, 32'h0FF0);
    next();
    set_req(1, 1'b1, 4'd7, -3, 2);
    repeat (6) begin
      @(negedge clk_i) chk("t3_ready0_blocked", 128'(req_ready[0]), 128'(0));
      next();
    end
    chk("t3_rsp1_slt", {rsp_res[1], rsp_zero[1]}, {32'd1, 1'b0});
    chk("t3_rsp0_held", {rsp_valid[0], rsp_res[0]}, {1'b1, 32'h0F00});
    req_valid[1] = 1'b0;
    next();
    next();
    rsp_ready[0] = 1'b1;
    @(negedge clk_i) chk("t3_release_grant", 128'(req_ready[0]), 128'(1));
    next();
    req_valid[0] = 1'b0;
    repeat (3) next();
    do_reset();
    n0 = n_acc;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) set_req(i, 1'b1, 4'($urandom_range(0, 7)), $urandom, $urandom);
    repeat (8) begin
      next();
      for (int i = 0; i < 2; i++) set_req(i, 1'b1, 4'($urandom_range(0, 7)), $urandom, $urandom);
    end
    req_valid = 2'b00;
    chk("t4_accepts", 128'(n_acc - n0), 128'(8));
    repeat (3) next();
    do_reset();
    set_req(1, 1'b1, 4'd2, 1, 2);
    next();
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1;
    #1 rst_i = 1'b1;
    #1 chk("t5_async_reset", {rsp_valid, req_ready, busy_o}, 128'(0));
    next();
    rst_i = 1'b0;
    req_valid = 2'b11;
    @(negedge clk_i) chk("t5_first_grant", 128'(req_ready), 128'(2'b01));
    next();
    req_valid = 2'b00;
    repeat (4) @(negedge clk_i) chk("t5_no_stale_rsp1", 128'(rsp_valid[1]), 128'(0));
    next();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        set_req(i, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom, $urandom);
        rsp_ready[i] = 1'($urandom_range(0, 3) != 0);
      end
      next();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (6) next();
    chk("drain_empty", {32'(sb[0].size()), 32'(sb[1].size()), 32'(mq[0].size()), 32'(mq[1].size())}, 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
